pipe_mac: RTL and testbench

Parametrised pipelined multiply / multiply-accumulate unit: successor to the fixed two-stage multiplier. It adds:
- configurable width and pipeline depth,
- per-beat signed/unsigned mode,
- an accumulate mode with end-of-group output,
- valid/ready flow control with full-pipeline stall.

It sits between the operand fetch logic and the convolution output path, producing either one product per beat or one dot-product per group.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mult_pipe_core.sv | 63 ++++++
 rtl/pipe_mac.sv | 65 ++++++
 tb/tb_pipe_mac.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, beat control struct and product extension helper for pipe_mac
package mac_pkg;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_PIPE_STAGES = 3;
    localparam int MAX_W           = 256;

    typedef struct packed {
        logic valid;
        logic is_signed;
        logic acc_en;
        logic last;
    } beat_ctrl_t;

    // Extends the low pw bits of p to MAX_W bits; the caller truncates to its accumulator width.
    function automatic logic [MAX_W-1:0] ext_product(input logic [MAX_W-1:0] p, input logic s,
                                                     input int pw);
        logic [MAX_W-1:0] m;
        logic             sb;
        m  = {MAX_W{1'b1}} << pw;
        sb = |(p & (MAX_W'(1) << (pw - 1)));
        return (s && sb) ? (p | m) : (p & ~m);
    endfunction
endpackage

// File: rtl/mult_pipe_core.sv
// mult_pipe_core: input register stage followed by the retimable multiply stages
// Ports: clk, rst (sync, active-high), en (advance all stages), a_i/b_i operands,
//        ctrl_i beat control; prod_o 2*DATA_WIDTH product and ctrl_o after PIPE_STAGES-1 stages.
module mult_pipe_core
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  beat_ctrl_t              ctrl_i,
    output logic [2*DATA_WIDTH-1:0] prod_o,
    output beat_ctrl_t              ctrl_o
);
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    beat_ctrl_t              c_q;
    logic [2*DATA_WIDTH-1:0] ax, bx, p;
    // The low 2*DATA_WIDTH bits of the product of the extended operands are correct for both modes.
    assign ax = {{DATA_WIDTH{c_q.is_signed & a_q[DATA_WIDTH-1]}}, a_q};
    assign bx = {{DATA_WIDTH{c_q.is_signed & b_q[DATA_WIDTH-1]}}, b_q};
    assign p  = ax * bx;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (en) begin
            a_q <= a_i;
            b_q <= b_i;
            c_q <= ctrl_i;
        end
    end
    generate
        if (PIPE_STAGES == 2) begin : g_comb
            assign prod_o = p;
            assign ctrl_o = c_q;
        end else begin : g_pipe
            logic [2*DATA_WIDTH-1:0] p_q [PIPE_STAGES-2];
            beat_ctrl_t              cp_q[PIPE_STAGES-2];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_STAGES - 2; i++) begin
                        p_q[i]  <= '0;
                        cp_q[i] <= '0;
                    end
                end else if (en) begin
                    p_q[0]  <= p;
                    cp_q[0] <= c_q;
                    for (int i = 1; i < PIPE_STAGES - 2; i++) begin
                        p_q[i]  <= p_q[i-1];
                        cp_q[i] <= cp_q[i-1];
                    end
                end
            end
            assign prod_o = p_q[PIPE_STAGES-3];
            assign ctrl_o = cp_q[PIPE_STAGES-3];
        end
    endgenerate
endmodule

// File: rtl/pipe_mac.sv
// pipe_mac: pipelined multiply / multiply-accumulate unit with valid/ready flow control
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, is_signed, acc_en, in_last
//        form an operand beat; out_valid/out_ready, out_data carry a product or group sum.
module pipe_mac
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH + 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_signed,
    input  logic                  acc_en,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data
);
    logic                    stall, val_q, val_d;
    beat_ctrl_t              ctrl_in, ctrl_m;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    ext, sum, acc_q, acc_d, out_q, out_d;
    // A held result blocks the whole pipe; in_ready is the only combinational path.
    assign stall    = val_q && !out_ready;
    assign in_ready = !stall;
    assign ctrl_in  = '{valid: in_valid, is_signed: is_signed, acc_en: acc_en, last: in_last};
    mult_pipe_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIPE_STAGES(PIPE_STAGES)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .en    (!stall),
        .a_i   (a),
        .b_i   (b),
        .ctrl_i(ctrl_in),
        .prod_o(prod),
        .ctrl_o(ctrl_m)
    );
    assign ext = ACC_WIDTH'(ext_product(MAX_W'(prod), ctrl_m.is_signed, 2 * DATA_WIDTH));
    assign sum = acc_q + ext;
    always_comb begin
        val_d = ctrl_m.valid && (!ctrl_m.acc_en || ctrl_m.last);
        out_d = !ctrl_m.valid ? out_q : !ctrl_m.acc_en ? ext : ctrl_m.last ? sum : out_q;
        acc_d = (ctrl_m.valid && ctrl_m.acc_en) ? (ctrl_m.last ? '0 : sum) : acc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= 1'b0;
            out_q <= '0;
            acc_q <= '0;
        end else if (!stall) begin
            val_q <= val_d;
            out_q <= out_d;
            acc_q <= acc_d;
        end
    end
    assign out_valid = val_q;
    assign out_data  = out_q;
endmodule

// File: tb/tb_pipe_mac.sv
// tb_pipe_mac: directed self-checking bench for pipe_mac (8-bit operands, 3 stages, 24- and 16-bit accumulators)
module tb_pipe_mac;
    localparam int DW  = 8;
    localparam int PS  = 3;
    localparam int AW  = 24;
    localparam int AW2 = 16;

    logic           clk = 0, rst = 1, in_valid = 0, is_signed = 0, acc_en = 0, in_last = 0, out_ready = 1;
    logic [DW-1:0]  a = '0, b = '0;
    logic           in_ready, out_valid, in_ready2, out_valid2;
    logic [AW-1:0]  out_data, held;
    logic [AW2-1:0] out_data2;
    logic [63:0]    exp_q[$];
    int             passed = 0, total = 0, sent = 0, got = 0;

    always #5 clk = ~clk;

    pipe_mac #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .is_signed(is_signed), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipe_mac #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(AW2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .is_signed(is_signed), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s,
                        input logic ac, input logic l);
        in_valid  = 1;
        a         = x;
        b         = y;
        is_signed = s;
        acc_en    = ac;
        in_last   = l;
        tick();
        in_valid  = 0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 1);
        rst = 0;

        // unsigned single 255*255
        send(8'd255, 8'd255, 0, 0, 0);
        chk("u_lat1", out_valid, 0);
        tick();
        chk("u_lat2", out_valid, 0);
        tick();
        chk("u_valid", out_valid, 1);
        chk("u_data", out_data, 64'd65025);
        tick();
        chk("u_pulse", out_valid, 0);
        chk("u_hold", out_data, 64'd65025);

        // signed -1 * 2
        send(8'hFF, 8'h02, 1, 0, 0);
        tick();
        tick();
        chk("s_valid", out_valid, 1);
        chk("s_data", out_data, 64'hFFFFFE);
        chk("s_data16", out_data2, 64'hFFFE);

        // group (3,4),(5,6),(-2,7) with an interleaved plain beat (2,2)
        send(8'd3, 8'd4, 1, 1, 0);
        send(8'd5, 8'd6, 1, 1, 0);
        send(8'd2, 8'd2, 0, 0, 0);
        chk("g_quiet0", out_valid, 0);
        send(8'hFE, 8'd7, 1, 1, 1);
        chk("g_quiet1", out_valid, 0);
        tick();
        chk("g_plain_v", out_valid, 1);
        chk("g_plain", out_data, 64'd4);
        tick();
        chk("g_sum_v", out_valid, 1);
        chk("g_sum", out_data, 64'd28);
        tick();
        chk("g_end", out_valid, 0);

        // wrap: two unsigned 255*255 accumulated
        send(8'd255, 8'd255, 0, 1, 0);
        send(8'd255, 8'd255, 0, 1, 1);
        tick();
        chk("w_quiet", out_valid2, 0);
        tick();
        chk("w_valid16", out_valid2, 1);
        chk("w_sum16", out_data2, 64'd64514);
        chk("w_sum24", out_data, 64'd130050);
        tick();

        // backpressure: 10 beats, out_ready low for cycles 5..8
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 5 && c <= 8);
            in_valid  = sent < 10;
            a         = DW'(sent + 1);
            b         = 8'd3;
            is_signed = 0;
            acc_en    = 0;
            in_last   = 0;
            #1;
            chk("bp_ready", in_ready, (c >= 5 && c <= 8) ? 1'b0 : 1'b1);
            if (c == 5) held = out_data;
            if (c >= 6 && c <= 8) begin
                chk("bp_hold", out_data, held);
                chk("bp_hold_v", out_valid, 1);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(64'((sent + 1) * 3));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("bp_q", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("bp_data", out_data, exp_q.pop_front());
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 0;
        out_ready = 1;
        chk("bp_count", got, 10);

        // reset mid-group
        send(8'd5, 8'd5, 0, 1, 0);
        send(8'd6, 8'd6, 0, 1, 0);
        tick();
        rst = 1;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_ready", in_ready, 1);
        chk("mr_ready16", in_ready2, 1);
        rst = 0;
        tick();
        chk("mr_after", out_valid, 0);
        send(8'd2, 8'd3, 0, 1, 1);
        tick();
        tick();
        chk("mr_one_v", out_valid, 1);
        chk("mr_one", out_data, 64'd6);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
